// File: rtl/gzip_block_sequencer_if.sv
// Handshake bundle between the block sequencer, the input FIFO and the LZ77/Huffman datapath.
// The master side is the sequencer; the slave side is the surrounding FIFO and datapath.
interface gzip_block_sequencer_if #(
    parameter int LEN_WIDTH = 24
);
    logic [1:0]           btype_in;
    logic                 fifo_empty;
    logic [31:0]          fifo_dout;
    logic                 fifo_rd_en;
    logic                 blk_start;
    logic                 blk_bfinal;
    logic [1:0]           blk_btype;
    logic [LEN_WIDTH-1:0] blk_len;
    logic [7:0]           byte_out;
    logic                 byte_valid;
    logic                 byte_ready;
    logic                 byte_last;
    logic                 blk_done;
    logic                 stream_done;
    logic                 err_len;

    modport master (
        input  btype_in,
        input  fifo_empty,
        input  fifo_dout,
        output fifo_rd_en,
        output blk_start,
        output blk_bfinal,
        output blk_btype,
        output blk_len,
        output byte_out,
        output byte_valid,
        input  byte_ready,
        output byte_last,
        input  blk_done,
        output stream_done,
        output err_len
    );

    modport slave (
        output btype_in,
        output fifo_empty,
        output fifo_dout,
        input  fifo_rd_en,
        input  blk_start,
        input  blk_bfinal,
        input  blk_btype,
        input  blk_len,
        input  byte_out,
        input  byte_valid,
        output byte_ready,
        input  byte_last,
        output blk_done,
        input  stream_done,
        input  err_len
    );
endinterface

// File: rtl/gzip_block_sequencer.sv
// Pops DEFLATE block headers and payload words from the input FIFO, announces each block and
// serialises its payload into a byte stream, dropping the padding lanes of the final word.
module gzip_block_sequencer #(
    parameter int LEN_WIDTH      = 24,
    parameter int MAX_STORED_LEN = 65535
) (
    input  logic                      clk,
    input  logic                      rst,
    gzip_block_sequencer_if.master    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_WAIT,
        S_HDR_PARSE,
        S_DATA_RD,
        S_DATA_WAIT,
        S_SHIFT,
        S_WAIT_DONE,
        S_ERROR
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [LEN_WIDTH-1:0] r_hdr_len;
    logic                 r_hdr_bfinal;
    logic                 r_blk_bfinal;
    logic [1:0]           r_blk_btype;
    logic [LEN_WIDTH-1:0] r_blk_len;
    logic [LEN_WIDTH-1:0] r_rem;
    logic [1:0]           r_lane;
    logic [31:0]          r_word;
    logic                 r_err_len;
    logic                 r_stream_done;

    logic                 w_fifo_rd_en;
    logic                 w_blk_start;
    logic                 w_byte_valid;
    logic                 w_hdr_bad;
    logic                 w_load_word;
    logic                 w_accept;
    logic                 w_done_final;
    logic                 w_out_en;
    logic [LEN_WIDTH-1:0] w_dout_len;
    logic [7:0]           w_lane_bytes [4];

    // Header LEN is stored most-significant byte first in bits [15:8].
    assign w_dout_len = LEN_WIDTH'({bus.fifo_dout[15:8], bus.fifo_dout[23:16], bus.fifo_dout[31:24]});

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane_bytes[gi] = r_word[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_fifo_rd_en = 1'b0;
        w_blk_start  = 1'b0;
        w_byte_valid = 1'b0;
        w_hdr_bad    = 1'b0;
        w_load_word  = 1'b0;
        w_accept     = 1'b0;
        w_done_final = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!bus.fifo_empty) begin
                    w_fifo_rd_en = 1'b1;
                    w_state_next = S_HDR_WAIT;
                end
            end
            S_HDR_WAIT: begin
                w_state_next = S_HDR_PARSE;
            end
            S_HDR_PARSE: begin
                if ((bus.btype_in == 2'b00) && (r_hdr_len > LEN_WIDTH'(MAX_STORED_LEN))) begin
                    w_hdr_bad    = 1'b1;
                    w_state_next = S_ERROR;
                end else begin
                    w_blk_start  = 1'b1;
                    w_state_next = (r_hdr_len == '0) ? S_WAIT_DONE : S_DATA_RD;
                end
            end
            S_DATA_RD: begin
                if (!bus.fifo_empty) begin
                    w_fifo_rd_en = 1'b1;
                    w_state_next = S_DATA_WAIT;
                end
            end
            S_DATA_WAIT: begin
                w_load_word  = 1'b1;
                w_state_next = S_SHIFT;
            end
            S_SHIFT: begin
                w_byte_valid = 1'b1;
                if (bus.byte_ready) begin
                    w_accept = 1'b1;
                    if (r_rem == LEN_WIDTH'(1)) begin
                        w_state_next = S_WAIT_DONE;
                    end else if (r_lane == 2'd3) begin
                        w_state_next = S_DATA_RD;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (bus.blk_done) begin
                    w_done_final = r_blk_bfinal;
                    w_state_next = S_IDLE;
                end
            end
            S_ERROR: begin
                w_state_next = S_ERROR;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hdr_len     <= '0;
            r_hdr_bfinal  <= 1'b0;
            r_blk_bfinal  <= 1'b0;
            r_blk_btype   <= 2'b00;
            r_blk_len     <= '0;
            r_rem         <= '0;
            r_lane        <= 2'd0;
            r_word        <= 32'd0;
            r_err_len     <= 1'b0;
            r_stream_done <= 1'b0;
        end else begin
            r_stream_done <= w_done_final;
            if (r_state == S_HDR_WAIT) begin
                r_hdr_len    <= w_dout_len;
                r_hdr_bfinal <= bus.fifo_dout[0];
            end
            if (w_hdr_bad) begin
                r_err_len <= 1'b1;
            end
            if (w_blk_start) begin
                r_blk_bfinal <= r_hdr_bfinal;
                r_blk_btype  <= bus.btype_in;
                r_blk_len    <= r_hdr_len;
                r_rem        <= r_hdr_len;
            end
            if (w_load_word) begin
                r_word <= bus.fifo_dout;
                r_lane <= 2'd0;
            end
            // Lane holds at 3 on the last byte of a word; it restarts only when a word is loaded.
            if (w_accept) begin
                r_rem <= r_rem - LEN_WIDTH'(1);
                if (r_lane != 2'd3) begin
                    r_lane <= r_lane + 2'd1;
                end
            end
        end
    end

    // Combinational outputs are forced low while reset is held so nothing leaks mid-reset.
    assign w_out_en        = ~rst;
    assign bus.fifo_rd_en  = w_fifo_rd_en & w_out_en;
    assign bus.blk_start   = w_blk_start & w_out_en;
    assign bus.blk_bfinal  = bus.blk_start ? r_hdr_bfinal : r_blk_bfinal;
    assign bus.blk_btype   = bus.blk_start ? bus.btype_in : r_blk_btype;
    assign bus.blk_len     = bus.blk_start ? r_hdr_len : r_blk_len;
    assign bus.byte_valid  = w_byte_valid & w_out_en;
    assign bus.byte_out    = bus.byte_valid ? w_lane_bytes[r_lane] : 8'd0;
    assign bus.byte_last   = bus.byte_valid & (r_rem == LEN_WIDTH'(1));
    assign bus.stream_done = r_stream_done;
    assign bus.err_len     = r_err_len;

endmodule

// File: tb/tb_gzip_block_sequencer.sv
// Directed bench for gzip_block_sequencer: a small FIFO model feeds header/payload words and
// each step checks block announcements, the byte stream, stalls, errors and reset recovery.
module tb_gzip_block_sequencer;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    gzip_block_sequencer_if #(.LEN_WIDTH(24)) bus ();

    gzip_block_sequencer #(
        .LEN_WIDTH      (24),
        .MAX_STORED_LEN (65535)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: pushes come from the stimulus block, pops land on fifo_dout one cycle later.
    logic [31:0] fifo_mem [0:63];
    int          wr_ptr;
    int          rd_ptr;
    logic        fifo_flush;
    logic [7:0]  exp_q [$];

    assign bus.fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_flush) begin
            rd_ptr <= wr_ptr;
        end else if (bus.fifo_rd_en && (rd_ptr != wr_ptr)) begin
            bus.fifo_dout <= fifo_mem[rd_ptr];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        fifo_mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_blk_start(input logic bf, input logic [1:0] bt, input logic [23:0] len);
        int cyc;
        cyc = 0;
        while (cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (bus.blk_start) break;
        end
        chk("blk_start_seen", bus.blk_start, 1);
        chk("blk_bfinal", bus.blk_bfinal, bf);
        chk("blk_btype", bus.blk_btype, bt);
        chk("blk_len", bus.blk_len, len);
        $display("blk_start bfinal=%0d btype=%0d len=%0d", bus.blk_bfinal, bus.blk_btype, bus.blk_len);
    endtask

    // Accepts n bytes from exp_q; toggle drives byte_ready 1,0,1,0...; last_idx marks byte_last.
    task automatic expect_stream(input int n, input bit toggle, input int last_idx);
        int         idx;
        int         cyc;
        bit         rdy;
        bit         stalled;
        logic [7:0] held;
        logic [7:0] exp_b;
        idx = 0;
        cyc = 0;
        stalled = 1'b0;
        held = 8'd0;
        while ((idx < n) && (cyc < 200)) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                chk("stall_valid_held", bus.byte_valid, 1);
                chk("stall_byte_held", bus.byte_out, held);
            end
            rdy = toggle ? (cyc % 2 == 1) : 1'b1;
            bus.byte_ready = rdy;
            stalled = 1'b0;
            if (bus.byte_valid) begin
                if (rdy) begin
                    exp_b = exp_q.pop_front();
                    chk("byte_out", bus.byte_out, exp_b);
                    chk("byte_last", bus.byte_last, (idx == last_idx) ? 1 : 0);
                    $display("byte %0d out=%h last=%0d", idx, bus.byte_out, bus.byte_last);
                    idx++;
                end else begin
                    held = bus.byte_out;
                    stalled = 1'b1;
                end
            end
        end
        chk("stream_count", idx, n);
    endtask

    task automatic finish_block(input logic exp_final);
        @(negedge clk);
        bus.byte_ready = 1'b0;
        chk("no_padding_byte", bus.byte_valid, 0);
        bus.blk_done = 1'b1;
        @(negedge clk);
        bus.blk_done = 1'b0;
        chk("stream_done", bus.stream_done, exp_final);
        @(negedge clk);
        chk("stream_done_one_cycle", bus.stream_done, 0);
        $display("block done final=%0d", exp_final);
    endtask

    initial begin
        int   lat;
        logic saw;

        n_checks = 0;
        n_fail = 0;
        wr_ptr = 0;
        rd_ptr = 0;
        fifo_flush = 1'b0;
        bus.fifo_dout = 32'd0;
        bus.btype_in = 2'b01;
        bus.byte_ready = 1'b0;
        bus.blk_done = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_fifo_rd_en", bus.fifo_rd_en, 0);
        chk("rst_byte_valid", bus.byte_valid, 0);
        chk("rst_blk_start", bus.blk_start, 0);
        chk("rst_err_len", bus.err_len, 0);
        chk("rst_stream_done", bus.stream_done, 0);
        rst = 1'b0;

        // T1: single final block "abcd"
        bus.btype_in = 2'b01;
        push(32'h04000001);
        push(32'h64636261);
        exp_q = '{8'h61, 8'h62, 8'h63, 8'h64};
        wait_blk_start(1'b1, 2'b01, 24'd4);
        lat = 0;
        while (!bus.byte_valid && (lat < 20)) begin
            @(negedge clk);
            lat++;
        end
        chk("first_byte_latency", lat, 3);
        expect_stream(4, 1'b0, 3);
        finish_block(1'b1);

        // T2: two blocks with padding in the last word of each
        bus.btype_in = 2'b10;
        push(32'h06000000);
        push(32'h64636261);
        push(32'hEEEE6665);
        push(32'h05000001);
        push(32'h62616867);
        push(32'hDDCCBB78);
        exp_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
        wait_blk_start(1'b0, 2'b10, 24'd6);
        expect_stream(6, 1'b0, 5);
        finish_block(1'b0);
        exp_q = '{8'h67, 8'h68, 8'h61, 8'h62, 8'h78};
        wait_blk_start(1'b1, 2'b10, 24'd5);
        expect_stream(5, 1'b0, 4);
        finish_block(1'b1);

        // T3: T1 with byte_ready toggling
        bus.btype_in = 2'b01;
        push(32'h04000001);
        push(32'h64636261);
        exp_q = '{8'h61, 8'h62, 8'h63, 8'h64};
        wait_blk_start(1'b1, 2'b01, 24'd4);
        expect_stream(4, 1'b1, 3);
        finish_block(1'b1);

        // T4: FIFO empty for 10 cycles between two payload words
        bus.btype_in = 2'b10;
        push(32'h08000001);
        push(32'h34333231);
        exp_q = '{8'h31, 8'h32, 8'h33, 8'h34};
        wait_blk_start(1'b1, 2'b10, 24'd8);
        expect_stream(4, 1'b0, -1);
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.byte_valid || bus.fifo_rd_en) saw = 1'b1;
        end
        chk("gap_quiet", saw, 0);
        push(32'h38373635);
        exp_q = '{8'h35, 8'h36, 8'h37, 8'h38};
        expect_stream(4, 1'b0, 3);
        finish_block(1'b1);

        // Zero-length stored block: legal, goes straight to waiting for blk_done
        bus.btype_in = 2'b00;
        push(32'h00000001);
        wait_blk_start(1'b1, 2'b00, 24'd0);
        finish_block(1'b1);

        // T5: stored block with LEN=70000 is rejected
        bus.btype_in = 2'b00;
        push(32'h70110100);
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.blk_start) saw = 1'b1;
        end
        chk("t5_no_blk_start", saw, 0);
        chk("t5_err_len", bus.err_len, 1);
        push(32'h04000001);
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.fifo_rd_en || bus.byte_valid) saw = 1'b1;
        end
        chk("t5_no_pop", saw, 0);
        chk("t5_err_sticky", bus.err_len, 1);
        rst = 1'b1;
        fifo_flush = 1'b1;
        @(negedge clk);
        chk("t5_rst_clears_err", bus.err_len, 0);
        rst = 1'b0;
        fifo_flush = 1'b0;
        $display("t5 error path done");

        // T6: reset during the 2nd byte of T1, then a clean T1
        bus.btype_in = 2'b01;
        push(32'h04000001);
        push(32'h64636261);
        exp_q = '{8'h61};
        wait_blk_start(1'b1, 2'b01, 24'd4);
        expect_stream(1, 1'b0, -1);
        @(negedge clk);
        chk("t6_second_byte", bus.byte_out, 8'h62);
        rst = 1'b1;
        bus.byte_ready = 1'b0;
        @(negedge clk);
        chk("t6_byte_valid", bus.byte_valid, 0);
        chk("t6_byte_out", bus.byte_out, 0);
        chk("t6_byte_last", bus.byte_last, 0);
        chk("t6_blk_len", bus.blk_len, 0);
        chk("t6_blk_bfinal", bus.blk_bfinal, 0);
        chk("t6_fifo_rd_en", bus.fifo_rd_en, 0);
        rst = 1'b0;
        push(32'h04000001);
        push(32'h64636261);
        exp_q = '{8'h61, 8'h62, 8'h63, 8'h64};
        wait_blk_start(1'b1, 2'b01, 24'd4);
        expect_stream(4, 1'b0, 3);
        finish_block(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
